// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol sequencer: letter codes, per-letter
// symbol counts and dot/dash patterns, and the sequencer state encoding.
package morse_pkg;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  localparam logic [2:0] LEN_A = 3'd2;
  localparam logic [2:0] LEN_B = 3'd4;
  localparam logic [2:0] LEN_C = 3'd4;
  localparam logic [2:0] LEN_D = 3'd3;
  localparam logic [2:0] LEN_E = 3'd1;
  localparam logic [2:0] LEN_F = 3'd4;
  localparam logic [2:0] LEN_G = 3'd3;
  localparam logic [2:0] LEN_H = 3'd4;

  // Bit i is symbol i (bit 0 goes out first); 1 = dash, 0 = dot.
  localparam logic [3:0] PAT_A = 4'b0010;  // .-
  localparam logic [3:0] PAT_B = 4'b0001;  // -...
  localparam logic [3:0] PAT_C = 4'b0101;  // -.-.
  localparam logic [3:0] PAT_D = 4'b0001;  // -..
  localparam logic [3:0] PAT_E = 4'b0000;  // .
  localparam logic [3:0] PAT_F = 4'b0100;  // ..-.
  localparam logic [3:0] PAT_G = 4'b0011;  // --.
  localparam logic [3:0] PAT_H = 4'b0000;  // ....

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/morse_rom.sv
// Combinational lookup from letter code to symbol count and dot/dash pattern.
module morse_rom
  import morse_pkg::*;
(
  input  logic [2:0] letter_i,
  output logic [2:0] len_o,
  output logic [3:0] pattern_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latch).
    len_o     = LEN_A;
    pattern_o = PAT_A;
    case (letter_i)
      LTR_A:   begin len_o = LEN_A; pattern_o = PAT_A; end
      LTR_B:   begin len_o = LEN_B; pattern_o = PAT_B; end
      LTR_C:   begin len_o = LEN_C; pattern_o = PAT_C; end
      LTR_D:   begin len_o = LEN_D; pattern_o = PAT_D; end
      LTR_E:   begin len_o = LEN_E; pattern_o = PAT_E; end
      LTR_F:   begin len_o = LEN_F; pattern_o = PAT_F; end
      LTR_G:   begin len_o = LEN_G; pattern_o = PAT_G; end
      LTR_H:   begin len_o = LEN_H; pattern_o = PAT_H; end
      default: begin len_o = LEN_A; pattern_o = PAT_A; end
    endcase
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Issues the dot/dash symbols of one latched letter over a valid/ready
// handshake, with a watchdog that aborts if the consumer stalls too long.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] letter,
  input  logic       sym_ready,
  output logic       sym_valid,
  output logic       sym_dash,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] cur_letter
);

  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0]      shift_q, shift_d;
  logic [2:0]      rem_q, rem_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [2:0]      cur_letter_q, cur_letter_d;
  logic            dash_q, dash_d;
  logic            err_q, err_d;

  logic [2:0]      rom_len;
  logic [3:0]      rom_pat;
  logic            xfer;

  morse_rom u_rom (
    .letter_i  (letter),
    .len_o     (rom_len),
    .pattern_o (rom_pat)
  );

  assign xfer = (state_q == ST_SEND) && sym_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    rem_d        = rem_q;
    wd_d         = wd_q;
    cur_letter_d = cur_letter_q;
    dash_d       = dash_q;
    err_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_letter_d = letter;
          shift_d      = rom_pat;
          rem_d        = rom_len;
          wd_d         = '0;
          dash_d       = rom_pat[0];
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        // A transfer on the watchdog's last cycle wins over the abort.
        if (xfer) begin
          shift_d = {1'b0, shift_q[3:1]};
          rem_d   = rem_q - 3'd1;
          wd_d    = '0;
          if (rem_q == 3'd1) state_d = ST_DONE;
          else               dash_d  = shift_q[1];
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values computed above, independent of statement order.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      rem_q        <= '0;
      wd_q         <= '0;
      cur_letter_q <= '0;
      dash_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      rem_q        <= rem_d;
      wd_q         <= wd_d;
      cur_letter_q <= cur_letter_d;
      dash_q       <= dash_d;
      err_q        <= err_d;
    end
  end

  assign sym_valid  = (state_q == ST_SEND);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q == ST_SEND) || (state_q == ST_DONE);
  assign sym_dash   = dash_q;
  assign err        = err_q;
  assign cur_letter = cur_letter_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed self-checking bench for morse_symbol_sequencer; inputs change and
// outputs are sampled on the falling clock edge.
module tb_morse_symbol_sequencer;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [2:0] letter;
  logic       sym_ready;
  logic       sym_valid;
  logic       sym_dash;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] cur_letter;

  int n_total = 0;
  int n_bad   = 0;

  morse_symbol_sequencer #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .letter     (letter),
    .sym_ready  (sym_ready),
    .sym_valid  (sym_valid),
    .sym_dash   (sym_dash),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cur_letter (cur_letter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Send one letter; ready is held high, or toggles 1,0,1,0... when tgl=1.
  task automatic send_letter(input logic [2:0] l, input bit tgl, input logic [3:0] pat,
                             input int len, input string tag);
    int k     = 0;
    int vcnt  = 0;
    int dones = 0;
    int errs  = 0;
    bit rdy;
    start  = 1'b1;
    letter = l;
    @(negedge clk);
    start  = 1'b0;
    letter = l ^ 3'b101;
    check({tag, "_cur_letter"}, cur_letter, l);
    for (int c = 0; c < 40 && dones == 0; c++) begin
      rdy       = tgl ? (c % 2 == 0) : 1'b1;
      sym_ready = rdy;
      if (sym_valid) begin
        vcnt++;
        check({tag, "_sym_in_range"}, k < len, 1);
        if (k < 4) check({tag, "_dash"}, sym_dash, pat[k]);
        check({tag, "_busy_send"}, busy, 1);
        if (rdy) k++;
      end
      if (done) begin
        dones++;
        check({tag, "_busy_done"}, busy, 1);
      end
      if (err) errs++;
      @(negedge clk);
    end
    check({tag, "_transfers"}, k, len);
    check({tag, "_valid_cycles"}, vcnt, tgl ? 2 * len - 1 : len);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_no_err"}, errs, 0);
    check({tag, "_done_low_after"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_cur_letter_hold"}, cur_letter, l);
    sym_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  vcnt;
    bit  got_err;
    bit  saw_done;

    resetn    = 1'b1;
    start     = 1'b0;
    letter    = 3'd0;
    sym_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", sym_valid, 0);
    check("rst_dash", sym_dash, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cur_letter", cur_letter, 0);
    resetn = 1'b0;
    @(negedge clk);
    check("idle_no_start", sym_valid, 0);

    // 1: A with ready held high: dot, dash.
    send_letter(3'd0, 1'b0, 4'b0010, 2, "A");

    // 2: F with ready toggling: dot, dot, dash, dot.
    send_letter(3'd5, 1'b1, 4'b0100, 4, "F");

    // 3: B with a stalled consumer -> watchdog abort after 16 valid cycles.
    start  = 1'b1;
    letter = 3'd1;
    @(negedge clk);
    start     = 1'b0;
    sym_ready = 1'b0;
    vcnt      = 0;
    got_err   = 1'b0;
    saw_done  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (err) begin
        got_err = 1'b1;
        break;
      end
      if (sym_valid) vcnt++;
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("to_err", got_err, 1);
    check("to_valid_cycles", vcnt, 16);
    check("to_valid_off", sym_valid, 0);
    check("to_idle", busy, 0);
    check("to_no_done", saw_done, 0);
    @(negedge clk);
    check("to_err_pulse", err, 0);

    // 4: E sent while start stays asserted with H -> ignored until idle.
    start     = 1'b1;
    letter    = 3'd4;
    @(negedge clk);
    letter    = 3'd7;
    sym_ready = 1'b1;
    check("E_valid", sym_valid, 1);
    check("E_dash", sym_dash, 0);
    @(negedge clk);
    check("E_done", done, 1);
    @(negedge clk);
    start = 1'b0;
    check("E_idle", busy, 0);
    check("E_start_ignored", cur_letter, 3'd4);
    send_letter(3'd7, 1'b0, 4'b0000, 4, "H");

    // 5: async reset in the middle of C after two transfers.
    start     = 1'b1;
    letter    = 3'd2;
    sym_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("C_third_valid", sym_valid, 1);
    check("C_third_dash", sym_dash, 1);
    #2 resetn = 1'b1;
    #1;
    check("C_rst_valid", sym_valid, 0);
    check("C_rst_dash", sym_dash, 0);
    check("C_rst_busy", busy, 0);
    check("C_rst_done", done, 0);
    check("C_rst_err", err, 0);
    check("C_rst_cur_letter", cur_letter, 0);
    sym_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("C_post_valid", sym_valid, 0);
    check("C_post_busy", busy, 0);
    @(negedge clk);
    check("C_post_valid2", sym_valid, 0);
    check("C_post_done", done, 0);

    // 6: D, ready rises exactly on the watchdog's final cycle.
    start  = 1'b1;
    letter = 3'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      sym_ready = 1'b0;
      check("D_wait_valid", sym_valid, 1);
      @(negedge clk);
    end
    sym_ready = 1'b1;
    check("D_edge_valid", sym_valid, 1);
    check("D_edge_dash", sym_dash, 1);
    @(negedge clk);
    check("D_edge_no_err", err, 0);
    check("D_s1_valid", sym_valid, 1);
    check("D_s1_dash", sym_dash, 0);
    @(negedge clk);
    check("D_s2_valid", sym_valid, 1);
    check("D_s2_dash", sym_dash, 0);
    @(negedge clk);
    check("D_done", done, 1);
    check("D_done_no_err", err, 0);
    sym_ready = 1'b0;
    @(negedge clk);
    check("D_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/morse_symbol_sequencer.md
Name: morse_symbol_sequencer

Overview:
Upstream stage of the dot/dash timing FSM. Accepts a 3-bit letter code (A..H), looks up its Morse pattern, and issues one symbol (dot or dash) at a time over a valid/ready handshake. The timing FSM asserts ready only while it is idle and enabled. The sequencer reports busy/done and flags a stalled consumer via a watchdog.

Parameters:
TIMEOUT, 16, max clk cycles sym_valid may wait for sym_ready before abort (>=2)
TO_W, 5, width of watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-high (asserting resetn=1 resets the block)
start  in  1  request to send letter; sampled only in IDLE
letter  in  3  letter code: 0=A 1=B 2=C 3=D 4=E 5=F 6=G 7=H
sym_ready  in  1  downstream timing FSM idle and accepting
sym_valid  out  1  symbol on sym_dash is valid
sym_dash  out  1  1=dash, 0=dot; meaningful only while sym_valid
busy  out  1  letter in progress (SEND or DONE)
done  out  1  one-cycle pulse after last symbol accepted
err  out  1  one-cycle pulse on watchdog abort
cur_letter  out  3  latched letter code of current/last transfer

Behaviour:
- Reset (resetn=1, async): state=IDLE; sym_valid=0, sym_dash=0, busy=0, done=0, err=0, cur_letter=0, shift reg=0, length=0, watchdog=0. Reset mid-letter abandons it; no done/err.
- Pattern table, symbol 0 sent first, bit i=1 means dash: A len2 .-; B len4 -...; C len4 -.-.; D len3 -..; E len1 .; F len4 ..-.; G len3 --.; H len4 .... .
- States: IDLE, SEND, DONE (registered, encoding free).
- IDLE: if start=1, latch cur_letter=letter, shift reg=pattern, remaining=len, watchdog=0, go SEND next cycle. start=0: stay.
- SEND: sym_valid=1, sym_dash=shift[0] (registered outputs). Transfer = sym_valid & sym_ready in the same cycle. On transfer: shift right by 1, remaining-=1, watchdog=0; if remaining was 1, go DONE (sym_valid=0 next cycle), else stay and present next symbol the next cycle with no bubble.
- Watchdog: in SEND without transfer, watchdog+=1; when it reaches TIMEOUT-1 with no transfer, next cycle err=1, sym_valid=0, go IDLE. A transfer in the same cycle as the limit takes precedence (no err).
- DONE: done=1 for exactly one cycle, busy=1; go IDLE. start during DONE is ignored.
- busy=1 in SEND and DONE. start while busy is ignored (not queued).
- letter changes after latch do not affect the transfer in progress.
- First symbol valid 1 cycle after start is sampled. Minimum letter time = len transfers + 1 DONE cycle.
- sym_dash holds its last value when sym_valid=0; the bench must not check it then.

Decomposition:
- Package morse_pkg: letter code constants (LTR_A..LTR_H), per-letter length and 4-bit pattern constants, state encoding constants.
- Sub-module morse_rom: combinational letter[2:0] -> len[2:0], pattern[3:0] lookup. Sequencer instantiates it once.

Test Plan:
1. Reset, start=1 letter=0 (A), sym_ready=1 -> sym_valid high for 2 cycles: dash=0 then 1; done pulses on the following cycle; busy low after.
2. letter=5 (F), sym_ready toggling 1,0,1,0 -> exactly 4 transfers in order 0,0,1,0; sym_dash stable while sym_ready=0; one done pulse.
3. letter=1 (B), sym_ready held 0 -> err pulses after TIMEOUT (16) cycles of sym_valid; state IDLE; no done.
4. letter=4 (E) sent; start re-asserted with letter=7 while busy -> ignored. After return to IDLE, start letter=7 -> 4 dot transfers.
5. resetn asserted mid-letter C after 2 transfers -> all outputs 0 immediately (asynchronous); after release, no residual sym_valid.
6. sym_ready rises in the same cycle the watchdog hits TIMEOUT-1 -> transfer accepted, no err, sequence continues.
